// File: rtl/video_gen_if.sv
// ============================================================================
// Module   : video_gen_if
// Brief    : Memory fetch port and video/status pins of the raster generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface video_gen_if;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic [7:0]  memData;
    logic        underrunClr;
    logic        underrun;
    logic        vblankIrq;
    logic        videoSync;
    logic        videoPixel;

    modport master (
        output memReq, memAddr, underrun, vblankIrq, videoSync, videoPixel,
        input  memAck, memData, underrunClr
    );

    modport slave (
        input  memReq, memAddr, underrun, vblankIrq, videoSync, videoPixel,
        output memAck, memData, underrunClr
    );
endinterface

`default_nettype wire

// File: rtl/video_gen.sv
// ============================================================================
// Module   : video_gen
// Brief    : Monochrome raster generator with byte prefetch and composite sync.
// Revision : 1.0
// ============================================================================
`default_nettype none

module video_gen #(
    parameter int unsigned H_TOTAL   = 512,
    parameter int unsigned H_SYNC    = 38,
    parameter int unsigned H_START   = 96,
    parameter int unsigned H_BYTES   = 32,
    parameter int unsigned V_TOTAL   = 312,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_START   = 40,
    parameter int unsigned V_LINES   = 192,
    parameter logic [15:0] BASE_ADDR = 16'hE000
) (
    input  wire logic   clk,
    input  wire logic   reset,
    video_gen_if.master bus
);

    localparam int          c_HW      = $clog2(H_TOTAL);
    localparam int          c_VW      = $clog2(V_TOTAL);
    localparam int unsigned c_H_END   = H_START + 8 * H_BYTES;
    localparam int unsigned c_V_END   = V_START + V_LINES;
    localparam logic [2:0]  c_H_PHASE = 3'(H_START % 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [c_HW-1:0] r_hcount;
    logic [c_VW-1:0] r_vcount;
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_memreq;
    logic [15:0]     r_addr;
    logic [7:0]      r_buf;
    logic [7:0]      r_shift;
    logic            r_underrun;
    logic            r_vblank;
    logic            r_sync;
    logic            r_pixel;

    logic [31:0] w_h;
    logic [31:0] w_v;
    logic        w_vact;
    logic        w_hact;
    logic        w_phase;
    logic        w_load;
    logic        w_slot;
    logic        w_sync;
    logic        w_vblank;
    logic [7:0]  w_load_byte;
    logic [7:0]  w_shift_cur;
    logic        w_set_underrun;
    logic        w_capture;

    assign w_h      = 32'(r_hcount);
    assign w_v      = 32'(r_vcount);
    assign w_vact   = (w_v >= V_START) && (w_v < c_V_END);
    assign w_hact   = (w_h >= H_START) && (w_h < c_H_END);
    assign w_phase  = (w_h[2:0] == c_H_PHASE);
    assign w_load   = w_vact && w_hact && w_phase;
    // Slot k begins one byte period before its load point, so slot k+1 shares load point k.
    assign w_slot   = w_vact && (w_h >= H_START - 8) && (w_h < c_H_END - 8) && w_phase;
    assign w_sync   = !((w_h < H_SYNC) || (w_v < V_SYNC));
    assign w_vblank = (w_h == 0) && (w_v == c_V_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_h == H_TOTAL - 1) begin
            r_hcount <= '0;
            r_vcount <= (w_v == V_TOTAL - 1) ? '0 : r_vcount + c_VW'(1);
        end else begin
            r_hcount <= r_hcount + c_HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_slot) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (w_load)           w_state_next = w_slot ? S_REQ : S_IDLE;
                else if (bus.memAck)  w_state_next = S_FULL;
            end
            S_FULL: begin
                if (w_load) w_state_next = w_slot ? S_REQ : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_byte    = 8'h00;
        w_set_underrun = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_load) begin
                    // An ack on the load cycle bypasses the buffer instead of counting as late.
                    w_load_byte    = bus.memAck ? bus.memData : 8'h00;
                    w_set_underrun = !bus.memAck;
                end else begin
                    w_capture = bus.memAck;
                end
            end
            S_FULL:  w_load_byte = r_buf;
            default: w_load_byte = 8'h00;
        endcase
        w_shift_cur = w_load ? w_load_byte : r_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memreq   <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_buf      <= 8'h00;
            r_shift    <= 8'h00;
            r_underrun <= 1'b0;
            r_vblank   <= 1'b0;
            r_sync     <= 1'b1;
            r_pixel    <= 1'b0;
        end else begin
            r_memreq <= (w_state_next == S_REQ);
            if ((w_h == 0) && (w_v == 0)) begin
                r_addr <= BASE_ADDR;
            end else if (w_load) begin
                r_addr <= r_addr + 16'd1;
            end
            if (w_capture) begin
                r_buf <= bus.memData;
            end
            r_shift <= {w_shift_cur[6:0], 1'b0};
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end else if (bus.underrunClr) begin
                r_underrun <= 1'b0;
            end
            r_vblank <= w_vblank;
            r_sync   <= w_sync;
            r_pixel  <= w_vact && w_hact && w_shift_cur[7];
        end
    end

    assign bus.memReq     = r_memreq;
    assign bus.memAddr    = r_addr;
    assign bus.underrun   = r_underrun;
    assign bus.vblankIrq  = r_vblank;
    assign bus.videoSync  = r_sync;
    assign bus.videoPixel = r_pixel;

endmodule

`default_nettype wire

// File: doc/video_gen.md
# video_gen

Raster video generator feeding the SoC's `videoSync`/`videoPixel` pins, downstream of the Z8 processor's video RAM. It walks a fixed frame timing and fetches one byte per 8 pixels from memory through a request/acknowledge port shared with the CPU bus arbiter. Fetched bytes pass through a one-byte prefetch buffer into a shift register, and are output MSB first as a monochrome pixel stream with composite sync. It also reports fetch underruns and raises a vertical-blank pulse for the processor's interrupt logic.

## Interface
Parameters:
- `H_TOTAL`, 512: clocks per line.
- `H_SYNC`, 38: sync clocks at line start.
- `H_START`, 96: first active hCount; must be ≥ 8.
- `H_BYTES`, 32: bytes per active line.
- `V_TOTAL`, 312: lines per frame.
- `V_SYNC`, 3: sync lines at frame start.
- `V_START`, 40: first active line.
- `V_LINES`, 192: active lines.
- `BASE_ADDR`, 16'hE000: address of byte 0 of line 0.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; one pixel per clock.
- `reset` in 1: synchronous, active-high.
- `memReq` out 1: fetch request.
- `memAddr` out 16: fetch address; stable while `memReq`=1.
- `memAck` in 1: data valid and request consumed this cycle.
- `memData` in 8: byte, sampled when `memAck`=1.
- `underrunClr` in 1: clears `underrun`.
- `underrun` out 1: sticky fetch-underrun flag.
- `vblankIrq` out 1: one-cycle vertical-blank pulse.
- `videoSync` out 1: composite sync, active low.
- `videoPixel` out 1: pixel, 1 = white.

## Operation
- Counters `hCount` 0..H_TOTAL-1 and `vCount` 0..V_TOTAL-1. `hCount` wraps to 0 and increments `vCount`; `vCount` wraps to 0 after V_TOTAL-1.
- Sync term is 0 when `hCount`<H_SYNC or `vCount`<V_SYNC, otherwise 1.
- Active region: `vCount` in [V_START, V_START+V_LINES) and `hCount` in [H_START, H_START+8·H_BYTES). Outside it, the pixel term is 0.
- Address counter: loaded with BASE_ADDR at `vCount`=0, `hCount`=0. It increments once per byte slot of an active line, whether the fetch succeeded or not, so line n starts at BASE_ADDR+n·H_BYTES. Arithmetic is 16-bit and wraps.
- Fetch FSM states: IDLE, REQ, FULL.
  - IDLE→REQ at the start of each byte slot of an active line. Slot k starts at `hCount`=H_START-8+8k, for k=0..H_BYTES-1.
  - In REQ: `memReq`=1 with the current address. On `memAck`, capture `memData` into the buffer and go to FULL.
  - FULL→IDLE when the buffer is loaded into the shift register.
- Load points are `hCount`=H_START+8k. At a load point:
  - FULL: the buffer goes to the shift register.
  - REQ with `memAck`=1 in the same cycle: `memData` bypasses straight into the shift register. This is not an underrun.
  - REQ without ack: load 0x00, set `underrun`, drop `memReq` next cycle, advance the address.
- Between load points the shift register shifts left once per clock; its MSB is the pixel term.
- `underrun` set has priority over `underrunClr` in the same cycle.
- `vblankIrq`=1 for the single cycle where `vCount`=V_START+V_LINES and `hCount`=0 (registered view).
- Reset mid-operation: the FSM returns to IDLE, any outstanding request is abandoned without waiting for an ack, and a late `memAck` is ignored.

## Timing
- Reset values:
  - `hCount`=`vCount`=0
  - `memReq`=0, `memAddr`=BASE_ADDR
  - `underrun`=0, `vblankIrq`=0
  - `videoSync`=1, `videoPixel`=0
- `videoSync`, `videoPixel` and `vblankIrq` are registered. The value for counter state (h,v) appears one cycle after the counters hold (h,v), so sync and pixel stay aligned.
- First cycle after reset deasserts: counters = (0,0). The next cycle shows `videoSync`=0.
- `memReq` and `memAddr` are registered. `memReq` rises the cycle after the slot start, and falls the cycle after `memAck` or after an underrun.
- Fetch budget per byte is 8 clocks minus 1 clock of request latency. An ack on the load-point cycle is still accepted.

## Test plan
Small parameters: H_TOTAL=40, H_SYNC=4, H_START=16, H_BYTES=2, V_TOTAL=6, V_SYNC=1, V_START=2, V_LINES=2, BASE_ADDR=16'h1000.
- Reset, then free-run one frame with `memAck` tied to `memReq`:
  - `videoSync`=0 for output cycles of lines 0 and hCount 0..3 of lines 1..5.
  - Frame length is 240 clocks.
- Memory returns 0xA5, 0x0F for line 2 (addresses 0x1000, 0x1001):
  - `videoPixel` shows 1010010100001111 for hCount 16..31 of line 2, delayed by one clock.
  - Line 3 requests 0x1002 and 0x1003.
- Ack withheld for byte 1 of line 2:
  - Pixels for hCount 24..31 are 0 and `underrun` goes to 1.
  - The next request uses address 0x1002.
  - Pulse `underrunClr`: `underrun` returns to 0.
- Ack arrives exactly at load cycle hCount=16: byte is displayed correctly and `underrun` stays 0.
- `vblankIrq`: exactly one pulse per frame, for the cycle after counters reach (h=0, v=4).
- Assert `reset` while `memReq`=1 on line 2:
  - Next cycle: `memReq`=0, `videoSync`=1, `memAddr`=0x1000.
  - A `memAck` during reset has no effect.
